// File: rtl/task8_timer_pkg.sv
// Shared types, segment codes and BCD helpers for the task8_timer stopwatch.
package task8_timer_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t s1;
    bcd_t s0;
    bcd_t d;
  } time_t;

  localparam time_t TIME_ZERO = '{s1: 4'd0, s0: 4'd0, d: 4'd0};

  // Advance S1 S0 . D by one tenth; 99.9 rolls over to 00.0.
  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (t.d != 4'd9) begin
      r.d = t.d + 4'd1;
    end else begin
      r.d = 4'd0;
      if (t.s0 != 4'd9) begin
        r.s0 = t.s0 + 4'd1;
      end else begin
        r.s0 = 4'd0;
        r.s1 = (t.s1 == 4'd9) ? 4'd0 : t.s1 + 4'd1;
      end
    end
    return r;
  endfunction

  // Two-digit BCD {tens, ones} of a value in 0..99.
  function automatic logic [7:0] num_to_bcd2(input int unsigned n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/task8_timer_hex_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; blank or non-BCD input
// turns all segments off.
module hex_decoder
  import task8_timer_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a default before the case so no path leaves it unassigned (no latch).
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/task8_timer.sv
// Tenths-of-a-second stopwatch with a small lap memory and 7-segment output.
module task8_timer
  import task8_timer_pkg::*;
#(
  parameter int DSEC_TICKS = 5_000_000,
  parameter int RES_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       key0_rst,
  input  logic       key1_start_stop,
  input  logic       key2_write,
  input  logic       key3_show,
  output logic [6:0] hex1_dsec,
  output logic [6:0] hex2_sec,
  output logic [6:0] hex3_sec,
  output logic [6:0] hex4_result,
  output logic [6:0] hex5_result
);

  localparam int PRE_W = (DSEC_TICKS > 1) ? $clog2(DSEC_TICKS) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DSEC_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_DEPTH);

  logic [2:0] keys, key_meta, key_sync, key_prev, press;
  logic       ss_press, wr_press, sh_press;

  logic [PRE_W-1:0] presc;
  logic             tick, running, show_mode;
  time_t            cur;
  logic [CNT_W-1:0] count, ptr_inc;
  logic [PTR_W-1:0] ptr, show_idx;
  logic             wr_en;

  time_t res_mem [RES_DEPTH];

  time_t shown_time;
  bcd_t  num_tens, num_ones;
  logic [6:0] seg1, seg2, seg3, seg4, seg5;

  // Keys idle high; the synchronizer resets to idle so reset release is not a press.
  assign keys = {key3_show, key2_write, key1_start_stop};

  always_ff @(posedge clk or posedge key0_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (key0_rst) begin
      key_meta <= '1;
      key_sync <= '1;
      key_prev <= '1;
    end else begin
      key_meta <= keys;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign press    = key_prev & ~key_sync;
  assign ss_press = press[0];
  assign wr_press = press[1];
  assign sh_press = press[2] & ~press[0] & ~press[1];

  assign tick    = running && (presc == PRE_LAST);
  assign wr_en   = wr_press && (count < CNT_FULL);
  assign ptr_inc = CNT_W'(ptr) + CNT_W'(1);

  always_ff @(posedge clk or posedge key0_rst) begin
    if (key0_rst) begin
      presc     <= '0;
      cur       <= TIME_ZERO;
      running   <= 1'b0;
      show_mode <= 1'b0;
      count     <= '0;
      ptr       <= '0;
      show_idx  <= '0;
    end else begin
      if (running) presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick)    cur   <= time_inc(cur);
      if (ss_press) begin
        running   <= ~running;
        show_mode <= 1'b0;
      end
      if (wr_en) count <= count + CNT_W'(1);
      if (sh_press && (count != '0)) begin
        show_mode <= 1'b1;
        show_idx  <= ptr;
        ptr       <= (ptr_inc == count) ? '0 : PTR_W'(ptr_inc);
      end
    end
  end

  // NOTE: the lap memory has no reset; key0_rst empties it by clearing count.
  always_ff @(posedge clk) begin
    if (wr_en) res_mem[count[PTR_W-1:0]] <= cur;
  end

  always_comb begin
    shown_time = cur;
    num_tens   = '0;
    num_ones   = '0;
    if (show_mode) begin
      shown_time             = res_mem[show_idx];
      {num_tens, num_ones}   = num_to_bcd2(32'(show_idx) + 32'd1);
    end
  end

  hex_decoder u_hex1 (.bcd(shown_time.d),  .blank(1'b0),       .seg(seg1));
  hex_decoder u_hex2 (.bcd(shown_time.s0), .blank(1'b0),       .seg(seg2));
  hex_decoder u_hex3 (.bcd(shown_time.s1), .blank(1'b0),       .seg(seg3));
  hex_decoder u_hex4 (.bcd(num_ones),      .blank(~show_mode), .seg(seg4));
  hex_decoder u_hex5 (.bcd(num_tens),      .blank(~show_mode), .seg(seg5));

  always_ff @(posedge clk or posedge key0_rst) begin
    if (key0_rst) begin
      hex1_dsec   <= SEG_0;
      hex2_sec    <= SEG_0;
      hex3_sec    <= SEG_0;
      hex4_result <= SEG_BLANK;
      hex5_result <= SEG_BLANK;
    end else begin
      hex1_dsec   <= seg1;
      hex2_sec    <= seg2;
      hex3_sec    <= seg3;
      hex4_result <= seg4;
      hex5_result <= seg5;
    end
  end

endmodule

// File: tb/tb_task8_timer.sv
// Directed bench for task8_timer with DSEC_TICKS=2 (one tenth every two cycles).
module tb_task8_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key1, key2, key3;
  logic [6:0] hex1, hex2, hex3, hex4, hex5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task8_timer #(.DSEC_TICKS(2), .RES_DEPTH(8)) dut (
    .clk             (clk),
    .key0_rst        (rst),
    .key1_start_stop (key1),
    .key2_write      (key2),
    .key3_show       (key3),
    .hex1_dsec       (hex1),
    .hex2_sec        (hex2),
    .hex3_sec        (hex3),
    .hex4_result     (hex4),
    .hex5_result     (hex5)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int s1, input int s0, input int d);
    check({tag, ".hex3"}, hex3, seg(s1));
    check({tag, ".hex2"}, hex2, seg(s0));
    check({tag, ".hex1"}, hex1, seg(d));
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".hex5"}, hex5, 7'h7F);
    check({tag, ".hex4"}, hex4, 7'h7F);
  endtask

  task automatic check_res(input string tag, input int n);
    check({tag, ".hex5"}, hex5, seg(n / 10));
    check({tag, ".hex4"}, hex4, seg(n % 10));
  endtask

  task automatic set_key(input int k, input logic v);
    if (k == 1) key1 = v;
    else if (k == 2) key2 = v;
    else key3 = v;
  endtask

  // Key goes low on the next falling edge and is held for three cycles.
  task automatic press(input int k);
    @(negedge clk);
    set_key(k, 1'b0);
    repeat (3) @(negedge clk);
    set_key(k, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Laps recorded while running, in tenths: 00.4 01.4 02.9 04.9 07.4
  int lap_s0 [5] = '{0, 1, 2, 4, 7};
  int lap_d  [5] = '{4, 4, 9, 9, 4};
  // Saturation run laps: 00.1 00.4 00.7 01.0 01.3 01.6 01.9 02.2
  int sat_s0 [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int sat_d  [8] = '{1, 4, 7, 0, 3, 6, 9, 2};

  initial begin
    rst  = 1'b1;
    key1 = 1'b1;
    key2 = 1'b1;
    key3 = 1'b1;
    repeat (3) @(negedge clk);
    check_time("in_reset", 0, 0, 0);
    check_blank("in_reset");
    rst = 1'b0;

    idle(10);
    check_time("idle", 0, 0, 0);
    check_blank("idle");

    press(3);
    idle(2);
    check_blank("show_empty");
    check_time("show_empty", 0, 0, 0);

    // Start, stop 20 cycles later: 10 tenths.
    press(1);
    idle(16);
    press(1);
    idle(2);
    check_time("run_1s", 0, 1, 0);
    idle(50);
    check_time("frozen", 0, 1, 0);

    // Resume for 24 cycles: 01.0 + 1.2.
    press(1);
    idle(20);
    press(1);
    idle(2);
    check_time("resume", 0, 2, 2);

    // 1954 cycles: 977 more tenths -> 99.9.
    press(1);
    idle(1950);
    press(1);
    idle(2);
    check_time("at_99_9", 9, 9, 9);

    // 3 more tenths wrap to 00.2.
    press(1);
    idle(2);
    press(1);
    idle(2);
    check_time("wrap", 0, 0, 2);

    // Five laps while running, then seven show presses.
    do_reset();
    press(1);
    idle(6);
    press(2);
    idle(16);
    press(2);
    idle(26);
    press(2);
    idle(36);
    press(2);
    idle(46);
    press(2);
    for (int i = 0; i < 7; i++) begin
      press(3);
      idle(2);
      check_res($sformatf("lap%0d", i), (i % 5) + 1);
      check_time($sformatf("lap%0d", i), 0, lap_s0[i % 5], lap_d[i % 5]);
    end
    press(1);
    idle(2);
    check_time("live_after_show", 0, 9, 8);
    check_blank("live_after_show");

    // Ten writes into eight slots; show wraps after the eighth.
    do_reset();
    press(1);
    for (int i = 0; i < 10; i++) begin
      press(2);
      idle(2);
    end
    press(1);
    for (int i = 0; i < 9; i++) begin
      press(3);
      idle(2);
      check_res($sformatf("sat%0d", i), (i % 8) + 1);
      check({$sformatf("sat%0d", i), ".hex2"}, hex2, seg(sat_s0[i % 8]));
      check({$sformatf("sat%0d", i), ".hex1"}, hex1, seg(sat_d[i % 8]));
    end

    // Reset while running in show mode takes effect without a clock edge.
    press(1);
    idle(4);
    press(3);
    idle(2);
    check_res("pre_reset", 2);
    #2 rst = 1'b1;
    #1;
    check_time("async_reset", 0, 0, 0);
    check_blank("async_reset");
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    check_time("after_reset", 0, 0, 0);
    press(3);
    idle(2);
    check_blank("cleared");
    check_time("cleared", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
